// File: rtl/rover_key_pkg.sv
// Shared definitions for the rover key PIO servicing logic.
//   - state_t      : servicing FSM states
//   - KEY_ADDR_*   : PIO register addresses (data, irq mask, edge capture)
//   - AVALON_DW    : Avalon-MM data width
package rover_key_pkg;

   localparam int unsigned AVALON_DW = 32;

   localparam logic [1:0] KEY_ADDR_DATA = 2'd0;
   localparam logic [1:0] KEY_ADDR_MASK = 2'd2;
   localparam logic [1:0] KEY_ADDR_EDGE = 2'd3;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      RD,
      WAIT,
      CLR,
      POST
   } state_t;

endpackage

// File: rtl/rover_key_event_hold.sv
// Holds one pending key event for the valid/ready stream.
// A load with a non-zero capture either posts a fresh event or, when the
// current event is still unconsumed, ORs the new keys in and flags overflow.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_load       : capture is final this cycle (FSM in POST)
//   i_cap        : captured edge bits
//   i_ready      : consumer accepts the event
//   i_ovf_clr    : clears the sticky overflow flag
//   o_valid      : event available
//   o_data       : event key bits
//   o_overflow   : sticky merge indicator
module rover_key_event_hold
   import rover_key_pkg::*;
#(
   parameter int unsigned KEY_W = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [KEY_W-1:0] i_cap,
   input  logic             i_ready,
   input  logic             i_ovf_clr,
   output logic             o_valid,
   output logic [KEY_W-1:0] o_data,
   output logic             o_overflow
);

   logic             r_valid;
   logic [KEY_W-1:0] r_data;
   logic             r_overflow;

   logic             w_valid_d;
   logic [KEY_W-1:0] w_data_d;
   logic             w_overflow_d;
   logic             w_ovf_set;

   always_comb begin
      w_valid_d = r_valid;
      w_data_d  = r_data;
      w_ovf_set = 1'b0;
      // A spurious (all-zero) capture leaves the event alone but must not
      // block the ordinary handshake.
      if (i_load && (|i_cap)) begin
         if (!r_valid || i_ready) begin
            w_data_d  = i_cap;
            w_valid_d = 1'b1;
         end else begin
            w_data_d  = r_data | i_cap;
            w_ovf_set = 1'b1;
         end
      end else if (r_valid && i_ready) begin
         w_valid_d = 1'b0;
      end
      // Set beats clear when both happen in one cycle.
      if (w_ovf_set) begin
         w_overflow_d = 1'b1;
      end else if (i_ovf_clr) begin
         w_overflow_d = 1'b0;
      end else begin
         w_overflow_d = r_overflow;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_valid    <= w_valid_d;
         r_data     <= w_data_d;
         r_overflow <= w_overflow_d;
      end
   end

   assign o_valid    = r_valid;
   assign o_data     = r_data;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/rover_key_irq_master.sv
// Avalon-MM initiator servicing the rover key PIO without CPU involvement.
// After reset it writes the irq mask; on each irq it reads edge capture,
// clears it, and hands the captured keys to the event holder.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   irq               : PIO level interrupt
//   address, chipselect, write_n, writedata : Avalon request (all registered)
//   readdata          : PIO read data, valid READ_LATENCY cycles after request
//   key_valid, key_data, key_ready : key event stream
//   overflow, overflow_clr         : sticky merge flag and its clear
module rover_key_irq_master
   import rover_key_pkg::*;
#(
   parameter int unsigned       KEY_W         = 2,
   parameter logic [KEY_W-1:0]  IRQ_MASK_INIT = 2'b11,
   parameter int unsigned       READ_LATENCY  = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 irq,
   output logic [1:0]           address,
   output logic                 chipselect,
   output logic                 write_n,
   output logic [AVALON_DW-1:0] writedata,
   input  logic [AVALON_DW-1:0] readdata,
   output logic                 key_valid,
   output logic [KEY_W-1:0]     key_data,
   input  logic                 key_ready,
   output logic                 overflow,
   input  logic                 overflow_clr
);

   localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

   state_t                 r_state;
   state_t                 w_state_d;
   logic [1:0]             r_wait_cnt;
   logic [1:0]             w_wait_cnt_d;
   logic [KEY_W-1:0]       r_cap;

   logic [1:0]             r_address;
   logic                   r_chipselect;
   logic                   r_write_n;
   logic [AVALON_DW-1:0]   r_writedata;

   logic [1:0]             w_address_d;
   logic                   w_chipselect_d;
   logic                   w_write_n_d;
   logic [AVALON_DW-1:0]   w_writedata_d;

   logic                   w_capture;
   logic                   w_load;
   logic                   w_unused_rd;

   // Next state. Bus outputs are registered from the next state, so r_state
   // always names the phase currently visible on the bus.
   always_comb begin
      w_state_d    = r_state;
      w_wait_cnt_d = r_wait_cnt;
      unique case (r_state)
         // Stay until the mask write has actually been on the bus one cycle.
         INIT:    if (r_chipselect) w_state_d = IDLE;
         IDLE:    if (irq) w_state_d = RD;
         RD: begin
            w_state_d    = WAIT;
            w_wait_cnt_d = WAIT_LAST;
         end
         WAIT: begin
            if (r_wait_cnt == 2'd0) begin
               w_state_d = CLR;
            end else begin
               w_wait_cnt_d = r_wait_cnt - 2'd1;
            end
         end
         CLR:     w_state_d = POST;
         POST:    w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   // Bus request for the state being entered.
   always_comb begin
      w_chipselect_d = 1'b0;
      w_write_n_d    = 1'b1;
      w_address_d    = KEY_ADDR_DATA;
      w_writedata_d  = '0;
      unique case (w_state_d)
         INIT: begin
            w_chipselect_d = 1'b1;
            w_write_n_d    = 1'b0;
            w_address_d    = KEY_ADDR_MASK;
            w_writedata_d  = {{(AVALON_DW-KEY_W){1'b0}}, IRQ_MASK_INIT};
         end
         RD: begin
            w_chipselect_d = 1'b1;
            w_address_d    = KEY_ADDR_EDGE;
         end
         WAIT: w_address_d = KEY_ADDR_EDGE;
         CLR: begin
            w_chipselect_d = 1'b1;
            w_write_n_d    = 1'b0;
            w_address_d    = KEY_ADDR_EDGE;
         end
         default: ;
      endcase
   end

   assign w_capture   = (r_state == WAIT) && (r_wait_cnt == 2'd0);
   assign w_load      = (r_state == POST);
   assign w_unused_rd = ^readdata[AVALON_DW-1:KEY_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= INIT;
         r_wait_cnt   <= 2'd0;
         r_cap        <= '0;
         r_address    <= KEY_ADDR_DATA;
         r_chipselect <= 1'b0;
         r_write_n    <= 1'b1;
         r_writedata  <= '0;
      end else begin
         r_state      <= w_state_d;
         r_wait_cnt   <= w_wait_cnt_d;
         r_address    <= w_address_d;
         r_chipselect <= w_chipselect_d;
         r_write_n    <= w_write_n_d;
         r_writedata  <= w_writedata_d;
         if (w_capture) r_cap <= readdata[KEY_W-1:0];
      end
   end

   assign address    = r_address;
   assign chipselect = r_chipselect;
   assign write_n    = r_write_n;
   assign writedata  = r_writedata;

   rover_key_event_hold #(
      .KEY_W (KEY_W)
   ) u_event_hold (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_load),
      .i_cap      (r_cap),
      .i_ready    (key_ready),
      .i_ovf_clr  (overflow_clr),
      .o_valid    (key_valid),
      .o_data     (key_data),
      .o_overflow (overflow)
   );

endmodule

// File: tb/tb_rover_key_irq_master.sv
// Self-checking bench: a PIO slave model drives irq/readdata, and a phase
// counter plus event model predicts bus and stream outputs every cycle.
module tb_rover_key_irq_master;

   localparam int RL      = 1;
   localparam int PH_PRE  = 100;
   localparam int PH_INIT = 101;
   localparam int PH_IDLE = -1;
   localparam int PH_CLR  = RL + 1;
   localparam int PH_POST = RL + 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        irq = 1'b0;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata = 32'h0;
   logic        key_valid;
   logic [1:0]  key_data;
   logic        key_ready = 1'b0;
   logic        overflow;
   logic        overflow_clr = 1'b0;

   int total = 0;
   int bad = 0;

   // Slave / model state
   logic [1:0] ec = 2'b00;
   logic [1:0] mask = 2'b00;
   logic [1:0] press = 2'b00;
   logic       spur = 1'b0;
   int         ph = PH_PRE;
   logic       m_valid = 1'b0;
   logic [1:0] m_data = 2'b00;
   logic       m_ovf = 1'b0;
   logic [1:0] m_cap = 2'b00;
   int         n_rd = 0;
   int         n_clr = 0;

   always #5 clk = ~clk;

   rover_key_irq_master #(
      .KEY_W         (2),
      .IRQ_MASK_INIT (2'b11),
      .READ_LATENCY  (RL)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .irq          (irq),
      .address      (address),
      .chipselect   (chipselect),
      .write_n      (write_n),
      .writedata    (writedata),
      .readdata     (readdata),
      .key_valid    (key_valid),
      .key_data     (key_data),
      .key_ready    (key_ready),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge of slave + reference model; DUT outputs read here are
   // the values of the cycle that just ended.
   task automatic monitor_step();
      logic        rd_cyc, wr_cyc, set;
      logic [1:0]  ec_old;
      logic [31:0] rnd;
      logic        e_cs, e_wn;
      logic [1:0]  e_addr;
      logic [31:0] e_wd;
      rd_cyc = chipselect && write_n && (address == 2'd3);
      wr_cyc = chipselect && !write_n;
      ec_old = ec;
      if (wr_cyc && address == 2'd2) mask = writedata[1:0];
      if (wr_cyc && address == 2'd3) ec = 2'b00;
      ec = ec | press;
      rnd = $urandom();
      readdata <= rd_cyc ? {rnd[31:2], ec_old} : rnd;
      irq <= (|(ec & mask)) | spur;
      if (rd_cyc) n_rd++;
      if (wr_cyc && address == 2'd3) n_clr++;

      if (!reset_n) begin
         ph = PH_PRE;
         m_valid = 1'b0;
         m_data = 2'b00;
         m_ovf = 1'b0;
         m_cap = 2'b00;
      end else begin
         e_cs = 1'b0; e_wn = 1'b1; e_addr = 2'd0; e_wd = 32'h0;
         if (ph == PH_INIT) begin
            e_cs = 1'b1; e_wn = 1'b0; e_addr = 2'd2; e_wd = 32'h3;
         end else if (ph == 0) begin
            e_cs = 1'b1; e_addr = 2'd3;
         end else if (ph >= 1 && ph <= RL) begin
            e_addr = 2'd3;
         end else if (ph == PH_CLR) begin
            e_cs = 1'b1; e_wn = 1'b0; e_addr = 2'd3;
         end
         chk("bus", {chipselect, write_n, address, writedata}, {e_cs, e_wn, e_addr, e_wd});
         chk("event", {key_valid, key_data, overflow}, {m_valid, m_data, m_ovf});

         if (ph == RL) m_cap = readdata[1:0];
         set = 1'b0;
         if (ph == PH_POST && m_cap != 2'b00) begin
            if (!m_valid || key_ready) begin
               m_data = m_cap;
               m_valid = 1'b1;
            end else begin
               m_data = m_data | m_cap;
               set = 1'b1;
            end
         end else if (m_valid && key_ready) begin
            m_valid = 1'b0;
         end
         if (set) m_ovf = 1'b1;
         else if (overflow_clr) m_ovf = 1'b0;

         if (ph == PH_PRE) ph = PH_INIT;
         else if (ph == PH_INIT) ph = PH_IDLE;
         else if (ph == PH_IDLE) ph = irq ? 0 : PH_IDLE;
         else if (ph == PH_POST) ph = PH_IDLE;
         else ph++;
      end
   endtask

   task automatic pulse_press(input logic [1:0] k);
      @(negedge clk) press = k;
      @(negedge clk) press = 2'b00;
   endtask

   task automatic stimulus();
      int n, rd0, cl0, rd_rel;
      // Reset and mask programming
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("init_write", {chipselect, write_n, address, writedata}, {1'b1, 1'b0, 2'd2, 32'h3});
      @(negedge clk);
      chk("idle_after_init", {chipselect, write_n, address, writedata}, {1'b0, 1'b1, 2'd0, 32'h0});

      // Single key0 press with consumer ready
      key_ready = 1'b1;
      rd0 = n_rd; cl0 = n_clr;
      pulse_press(2'b01);
      chk("irq_rise", irq, 1'b1);
      n = 0;
      while (!key_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, 5);
      chk("key0_data", key_data, 2'b01);
      @(negedge clk);
      chk("valid_fall", key_valid, 1'b0);
      chk("rd_count", n_rd - rd0, 1);
      chk("clr_count", n_clr - cl0, 1);

      // Merge while consumer stalled, then clear overflow
      key_ready = 1'b0;
      pulse_press(2'b01);
      n = 0;
      while (!key_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("wait_kv", key_valid, 1'b1);
      pulse_press(2'b10);
      n = 0;
      while (!overflow && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("merged", {key_valid, key_data, overflow}, 4'b1111);
      @(negedge clk) overflow_clr = 1'b1;
      @(negedge clk) overflow_clr = 1'b0;
      chk("ovf_cleared", {key_valid, key_data, overflow}, 4'b1110);

      // Handshake coincides with the POST edge
      pulse_press(2'b10);
      n = 0;
      while (!(chipselect && !write_n && address == 2'd3) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("wait_clr", {chipselect, write_n, address}, {1'b1, 1'b0, 2'd3});
      @(negedge clk) key_ready = 1'b1;
      @(negedge clk);
      chk("post_handshake", {key_valid, key_data, overflow}, 4'b1100);
      @(negedge clk);
      chk("post_consumed", key_valid, 1'b0);

      // Spurious irq
      rd0 = n_rd; cl0 = n_clr;
      @(negedge clk) spur = 1'b1;
      @(negedge clk) spur = 1'b0;
      repeat (10) @(negedge clk);
      chk("spur_rd", n_rd - rd0, 1);
      chk("spur_clr", n_clr - cl0, 1);
      chk("spur_no_event", {key_valid, overflow}, 2'b00);

      // Reset during WAIT
      key_ready = 1'b0;
      pulse_press(2'b01);
      n = 0;
      while (!(chipselect && write_n && address == 2'd3) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("wait_rd", {chipselect, write_n, address}, {1'b1, 1'b1, 2'd3});
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk("async_reset",
             {chipselect, write_n, address, writedata, key_valid, key_data, overflow},
             {1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 2'b00, 1'b0});
      @(negedge clk);
      @(negedge clk) reset_n = 1'b1;
      rd_rel = n_rd;
      @(posedge clk);
      @(negedge clk);
      chk("reinit_write", {chipselect, write_n, address, writedata}, {1'b1, 1'b0, 2'd2, 32'h3});
      chk("no_read_before_init", n_rd - rd_rel, 0);

      // Randomized traffic with one mid-run reset
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         press = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         key_ready = ($urandom_range(0, 3) != 0);
         overflow_clr = ($urandom_range(0, 15) == 0);
         spur = ($urandom_range(0, 39) == 0);
         reset_n = (i != 300);
      end
      @(negedge clk);
      press = 2'b00; spur = 1'b0; overflow_clr = 1'b0; reset_n = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      fork
         forever begin
            @(posedge clk);
            monitor_step();
         end
         stimulus();
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
